axi_lite_rd_arbiter: RTL and testbench
======================================

AXI_LITE_RD_ARBITER -- requirements
Module: axi_lite_rd_arbiter

Interface
REQ-001 The block SHALL have parameter: DATA_W, 32, address/data width (equals `CPU_WIDTH).
REQ-002 The block SHALL have port: i_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port: i_rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have ports: m0_araddr, m1_araddr  input  DATA_W  master read address.
REQ-005 The block SHALL have ports: m0_arvalid, m1_arvalid  input  1  master address valid.
REQ-006 The block SHALL have ports: m0_arready, m1_arready  output  1  master address accepted.
REQ-007 The block SHALL have ports: m0_rdata, m1_rdata  output  DATA_W  read data to master.
REQ-008 The block SHALL have ports: m0_rresp, m1_rresp  output  2  read response to master.
REQ-009 The block SHALL have ports: m0_rvalid, m1_rvalid  output  1  read data valid to master.
REQ-010 The block SHALL have ports: m0_rready, m1_rready  input  1  master ready for data.
REQ-011 The block SHALL have ports: s_araddr  output  DATA_W, s_arvalid  output  1, s_arready  input  1  slave AR channel.
REQ-012 The block SHALL have ports: s_rdata  input  DATA_W, s_rresp  input  2, s_rvalid  input  1, s_rready  output  1  slave R channel.

Function
REQ-013 The block SHALL implement FSM states IDLE, ADDR, DATA, with at most one outstanding read.
REQ-014 IDLE: when any mX_arvalid=1, it SHALL select one master, assert only that master's mX_arready combinationally in the same cycle, latch its araddr and the grant, and go to ADDR.
REQ-015 Both arvalid=1 in IDLE: it SHALL grant the master not granted last (round-robin); last_grant resets to 1, so m0 wins the first tie.
REQ-016 A master dropping arvalid before arready SHALL NOT be captured; mX_arready SHALL be 0 in ADDR and DATA.
REQ-017 ADDR: s_arvalid=1 and s_araddr=latched address; on s_arready=1, go to DATA; s_arvalid SHALL be 0 in all other states.
REQ-018 s_araddr SHALL remain stable while s_arvalid=1 and s_arready=0.
REQ-019 DATA: s_rdata, s_rresp, s_rvalid SHALL pass combinationally to the granted master; s_rready = granted master's rready; non-granted master sees rvalid=0, rdata=0, rresp=0.
REQ-020 DATA: on s_rvalid && granted rready, update last_grant and return to IDLE; the next grant is possible no earlier than the following cycle.
REQ-021 s_rready SHALL be 0 outside DATA; s_rvalid outside DATA SHALL be ignored.
REQ-022 Added latency: AR path 1 cycle (mX_arready at N -> s_arvalid at N+1); R path 0 cycles.
REQ-023 A response with rresp!=0 SHALL be forwarded unchanged and complete the transaction normally.

Reset
REQ-024 While i_rst=1, the FSM SHALL go to IDLE, last_grant=1, latched address=0, and all outputs SHALL be 0 at the next edge.
REQ-025 Reset mid-transaction (ADDR or DATA) SHALL abandon the transaction with no response delivered to any master.

Configuration
REQ-026 Macro ARB_FIXED_PRIO_EN defined: m0 SHALL always win ties and last_grant SHALL be unused; undefined: round-robin per REQ-015.

Verification
REQ-027 Single read: m0_arvalid, addr 0xa0000000; slave arready 1 cycle later, rdata 0x41 -> m0 gets arready at N, s_arvalid at N+1, m0_rvalid with 0x41, m1 outputs stay 0.
REQ-028 Tie after reset: both arvalid, addrs 0x100/0x200, requests held -> grants m0, m1, m0 in order, s_araddr 0x100, 0x200, 0x100; with ARB_FIXED_PRIO_EN -> m0 only.
REQ-029 Backpressure: s_arready held low 5 cycles, then m0_rready low 3 cycles after s_rvalid -> s_araddr stable, s_rready low with m0_rready, a single completion.
REQ-030 Error response: s_rresp=2'b10 -> m1_rresp=2'b10, FSM returns to IDLE.
REQ-031 Reset in DATA: assert i_rst with s_rvalid pending -> all outputs 0 next cycle, next request granted m0 first.

Source files
------------

// File: rtl/axi_lite_rd_arbiter_if.sv
// AXI-Lite read-only channel bundle (AR + R) shared by the masters and the slave
// of the read arbiter; master drives the request, slave drives the response.
interface axi_lite_rd_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_rd_arbiter.sv
// Two-master AXI-Lite read arbiter with one outstanding read and round-robin ties.
// Define ARB_FIXED_PRIO_EN to make m0 win every tie instead of alternating.
module axi_lite_rd_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  axi_lite_rd_arbiter_if.slave  m0,
  axi_lite_rd_arbiter_if.slave  m1,
  axi_lite_rd_arbiter_if.master s
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;   // 0 = m0, 1 = m1
  logic [DATA_W-1:0] addr_q, addr_d;
`ifndef ARB_FIXED_PRIO_EN
  logic              last_grant_q, last_grant_d;
`endif

  logic pick;
  logic accept;
  logic in_data;
  logic granted_rready;

  assign in_data        = (state_q == DATA);
  assign granted_rready = grant_q ? m1.rready : m0.rready;

  // Which master would be granted if a request is accepted this cycle.
  always_comb begin
    pick = m1.arvalid;
    if (m0.arvalid && m1.arvalid) begin
`ifdef ARB_FIXED_PRIO_EN
      pick = 1'b0;
`else
      pick = ~last_grant_q;
`endif
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    accept  = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        // No handshake while reset is held, so every output reads 0 in reset.
        if ((m0.arvalid || m1.arvalid) && !i_rst) begin
          accept  = 1'b1;
          grant_d = pick;
          addr_d  = pick ? m1.araddr : m0.araddr;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (s.arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (s.rvalid && granted_rready) begin
`ifndef ARB_FIXED_PRIO_EN
          last_grant_d = grant_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      addr_q       <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // AR side: accept combinationally in IDLE, present the latched address in ADDR.
  assign m0.arready = accept & ~pick;
  assign m1.arready = accept &  pick;
  assign s.arvalid  = (state_q == ADDR);
  assign s.araddr   = addr_q;

  // R side: zero-latency pass-through to the granted master only.
  assign s.rready  = in_data & granted_rready;

  assign m0.rvalid = in_data & ~grant_q & s.rvalid;
  assign m0.rdata  = (in_data && !grant_q) ? s.rdata : '0;
  assign m0.rresp  = (in_data && !grant_q) ? s.rresp : 2'b00;

  assign m1.rvalid = in_data & grant_q & s.rvalid;
  assign m1.rdata  = (in_data && grant_q) ? s.rdata : '0;
  assign m1.rresp  = (in_data && grant_q) ? s.rresp : 2'b00;

  // Protocol invariants of the arbiter's own outputs.
  a_arready_onehot : assert property (@(posedge i_clk) disable iff (i_rst)
    !(m0.arready && m1.arready));

  a_arready_idle_only : assert property (@(posedge i_clk) disable iff (i_rst)
    (m0.arready || m1.arready) |-> (state_q == IDLE));

  a_araddr_stable : assert property (@(posedge i_clk) disable iff (i_rst)
    (s.arvalid && !s.arready) |=> $stable(s.araddr));

  a_rready_data_only : assert property (@(posedge i_clk) disable iff (i_rst)
    s.rready |-> in_data);

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed table-driven bench for axi_lite_rd_arbiter plus hand-written
// backpressure and reset-during-DATA sequences.
module tb_axi_lite_rd_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic        rst;
    logic        m0_arvalid;
    logic [31:0] m0_araddr;
    logic        m0_rready;
    logic        m1_arvalid;
    logic [31:0] m1_araddr;
    logic        m1_rready;
    logic        s_arready;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
  } in_t;

  typedef struct packed {
    logic        m0_arready;
    logic        m1_arready;
    logic        s_arvalid;
    logic [31:0] s_araddr;
    logic        s_rready;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic [1:0]  m1_rresp;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  vec_t tbl[$];

  axi_lite_rd_arbiter_if #(.DATA_W(32)) m0_if ();
  axi_lite_rd_arbiter_if #(.DATA_W(32)) m1_if ();
  axi_lite_rd_arbiter_if #(.DATA_W(32)) s_if ();

  axi_lite_rd_arbiter #(.DATA_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk_in(input logic rst_v,
                                input logic v0, input logic [31:0] a0, input logic r0,
                                input logic v1, input logic [31:0] a1, input logic r1,
                                input logic sar, input logic srv,
                                input logic [31:0] sd, input logic [1:0] sr);
    in_t x;
    x.rst = rst_v;
    x.m0_arvalid = v0; x.m0_araddr = a0; x.m0_rready = r0;
    x.m1_arvalid = v1; x.m1_araddr = a1; x.m1_rready = r1;
    x.s_arready = sar; x.s_rvalid = srv; x.s_rdata = sd; x.s_rresp = sr;
    return x;
  endfunction

  function automatic out_t mk_out(input logic ar0, input logic ar1, input logic sav,
                                  input logic [31:0] sa, input logic srr,
                                  input logic rv0, input logic [31:0] d0, input logic [1:0] r0,
                                  input logic rv1, input logic [31:0] d1, input logic [1:0] r1);
    out_t o;
    o.m0_arready = ar0; o.m1_arready = ar1; o.s_arvalid = sav; o.s_araddr = sa;
    o.s_rready = srr;
    o.m0_rvalid = rv0; o.m0_rdata = d0; o.m0_rresp = r0;
    o.m1_rvalid = rv1; o.m1_rdata = d1; o.m1_rresp = r1;
    return o;
  endfunction

  // Expected outputs in DATA with s_rvalid=1 routed to master g.
  function automatic out_t mk_dat(input logic g, input logic [31:0] sa, input logic srr,
                                  input logic [31:0] d, input logic [1:0] r);
    return mk_out(1'b0, 1'b0, 1'b0, sa, srr,
                  !g, g ? 32'h0 : d, g ? 2'b00 : r,
                  g, g ? d : 32'h0, g ? r : 2'b00);
  endfunction

  task automatic drive(input in_t x);
    rst = x.rst;
    m0_if.arvalid = x.m0_arvalid; m0_if.araddr = x.m0_araddr; m0_if.rready = x.m0_rready;
    m1_if.arvalid = x.m1_arvalid; m1_if.araddr = x.m1_araddr; m1_if.rready = x.m1_rready;
    s_if.arready = x.s_arready; s_if.rvalid = x.s_rvalid;
    s_if.rdata = x.s_rdata; s_if.rresp = x.s_rresp;
  endtask

  function automatic out_t sample();
    return mk_out(m0_if.arready, m1_if.arready, s_if.arvalid, s_if.araddr, s_if.rready,
                  m0_if.rvalid, m0_if.rdata, m0_if.rresp,
                  m1_if.rvalid, m1_if.rdata, m1_if.rresp);
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, compare shortly after, clock advances on the rising edge.
  task automatic step(input string name, input in_t x, input out_t exp);
    @(negedge clk);
    drive(x);
    #1;
    check(name, sample(), exp);
  endtask

  task automatic add(input string name, input in_t x, input out_t exp);
    vec_t v;
    v.name = name; v.stim = x; v.exp = exp;
    tbl.push_back(v);
  endtask

  localparam out_t ZERO = '0;

  initial begin
    logic        g2;
    logic [31:0] a2;
    n_vec = 0;
    n_bad = 0;
    g2 = FIXED ? 1'b0 : 1'b1;
    a2 = FIXED ? 32'h100 : 32'h200;

    // Reset state
    add("reset_outputs", mk_in(1,0,0,0, 0,0,0, 0,0,0,0), ZERO);

    // Single read from m0
    add("single_arready", mk_in(0,1,32'ha000_0000,1, 0,0,0, 0,0,0,0),
        mk_out(1,0,0,32'h0,0, 0,0,0, 0,0,0));
    add("single_s_arvalid", mk_in(0,0,0,1, 0,0,0, 1,0,0,0),
        mk_out(0,0,1,32'ha000_0000,0, 0,0,0, 0,0,0));
    add("single_rdata", mk_in(0,0,0,1, 0,0,0, 0,1,32'h41,0),
        mk_dat(0,32'ha000_0000,1,32'h41,0));
    add("single_idle", mk_in(0,0,0,1, 0,0,0, 0,0,0,0),
        mk_out(0,0,0,32'ha000_0000,0, 0,0,0, 0,0,0));

    // Error response to m1, stray s_rvalid afterwards ignored
    add("err_arready", mk_in(0,0,0,1, 1,32'h3000,1, 0,0,0,0),
        mk_out(0,1,0,32'ha000_0000,0, 0,0,0, 0,0,0));
    add("err_s_arvalid", mk_in(0,0,0,1, 0,0,1, 1,0,0,0),
        mk_out(0,0,1,32'h3000,0, 0,0,0, 0,0,0));
    add("err_rresp", mk_in(0,0,0,1, 0,0,1, 0,1,32'hdead_beef,2'b10),
        mk_dat(1,32'h3000,1,32'hdead_beef,2'b10));
    add("err_back_idle", mk_in(0,0,0,1, 0,0,1, 0,1,32'h55,0),
        mk_out(0,0,0,32'h3000,0, 0,0,0, 0,0,0));

    // Tie with requests held: slave always ready, data always valid
    add("tie1_grant", mk_in(0,1,32'h100,1, 1,32'h200,1, 1,1,32'h11,0),
        mk_out(1,0,0,32'h3000,0, 0,0,0, 0,0,0));
    add("tie1_addr", mk_in(0,1,32'h100,1, 1,32'h200,1, 1,1,32'h11,0),
        mk_out(0,0,1,32'h100,0, 0,0,0, 0,0,0));
    add("tie1_data", mk_in(0,1,32'h100,1, 1,32'h200,1, 1,1,32'h11,0),
        mk_dat(0,32'h100,1,32'h11,0));
    add("tie2_grant", mk_in(0,1,32'h100,1, 1,32'h200,1, 1,1,32'h22,0),
        mk_out(!g2,g2,0,32'h100,0, 0,0,0, 0,0,0));
    add("tie2_addr", mk_in(0,1,32'h100,1, 1,32'h200,1, 1,1,32'h22,0),
        mk_out(0,0,1,a2,0, 0,0,0, 0,0,0));
    add("tie2_data", mk_in(0,1,32'h100,1, 1,32'h200,1, 1,1,32'h22,0),
        mk_dat(g2,a2,1,32'h22,0));
    add("tie3_grant", mk_in(0,1,32'h100,1, 1,32'h200,1, 1,1,32'h33,0),
        mk_out(1,0,0,a2,0, 0,0,0, 0,0,0));
    add("tie3_addr", mk_in(0,1,32'h100,1, 1,32'h200,1, 1,1,32'h33,0),
        mk_out(0,0,1,32'h100,0, 0,0,0, 0,0,0));
    add("tie3_data", mk_in(0,1,32'h100,1, 1,32'h200,1, 1,1,32'h33,0),
        mk_dat(0,32'h100,1,32'h33,0));
    add("tie_drop_idle", mk_in(0,0,0,1, 0,0,1, 1,1,32'h44,0),
        mk_out(0,0,0,32'h100,0, 0,0,0, 0,0,0));

    drive(mk_in(1,0,0,0, 0,0,0, 0,0,0,0));
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].name, tbl[i].stim, tbl[i].exp);
    end

    // Backpressure: slave AR stalls 5 cycles, then m0 holds off R for 3 cycles
    step("bp_arready", mk_in(0,1,32'hcafe_0000,1, 0,0,0, 0,0,0,0),
         mk_out(1,0,0,32'h100,0, 0,0,0, 0,0,0));
    for (int k = 0; k < 5; k++) begin
      step($sformatf("bp_ar_stall%0d", k), mk_in(0,0,0,1, 0,0,0, 0,0,0,0),
           mk_out(0,0,1,32'hcafe_0000,0, 0,0,0, 0,0,0));
    end
    step("bp_ar_accept", mk_in(0,0,0,1, 0,0,0, 1,0,0,0),
         mk_out(0,0,1,32'hcafe_0000,0, 0,0,0, 0,0,0));
    for (int k = 0; k < 3; k++) begin
      step($sformatf("bp_r_stall%0d", k), mk_in(0,0,0,0, 0,0,1, 0,1,32'h77,0),
           mk_dat(0,32'hcafe_0000,0,32'h77,0));
    end
    step("bp_r_done", mk_in(0,0,0,1, 0,0,0, 0,1,32'h77,0),
         mk_dat(0,32'hcafe_0000,1,32'h77,0));
    step("bp_single", mk_in(0,0,0,1, 0,0,0, 0,1,32'h77,0),
         mk_out(0,0,0,32'hcafe_0000,0, 0,0,0, 0,0,0));

    // Reset while m1's response is pending in DATA
    step("rst_arready", mk_in(0,0,0,0, 1,32'h500,0, 0,0,0,0),
         mk_out(0,1,0,32'hcafe_0000,0, 0,0,0, 0,0,0));
    step("rst_addr", mk_in(0,0,0,0, 0,0,0, 1,0,0,0),
         mk_out(0,0,1,32'h500,0, 0,0,0, 0,0,0));
    step("rst_pending", mk_in(0,0,0,0, 0,0,0, 0,1,32'h99,0),
         mk_dat(1,32'h500,0,32'h99,0));
    step("rst_assert", mk_in(1,0,0,0, 0,0,0, 0,1,32'h99,0),
         mk_dat(1,32'h500,0,32'h99,0));
    step("rst_outputs_zero", mk_in(1,0,0,1, 0,0,1, 1,1,32'h99,0), ZERO);
    step("rst_tie_m0", mk_in(0,1,32'h100,1, 1,32'h200,1, 0,1,32'h99,0),
         mk_out(1,0,0,32'h0,0, 0,0,0, 0,0,0));
    step("rst_tie_addr", mk_in(0,0,0,1, 0,0,1, 0,0,0,0),
         mk_out(0,0,1,32'h100,0, 0,0,0, 0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
